alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the N-bit adder/ALU datapath.
- Captures the adder's sum and carry-out together with operand sign bits and the operation code, and derives Z/N/C/V flags.
- Presents result and flags to the consumer (register-file write-back or status register) over a valid/ready handshake.
- Internal 2-entry skid buffer: full throughput and a registered in_ready.

Parameters:
- N, 4, datapath width; must match the upstream adder.
- CNT_W, 16, width of the accepted-result counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream result word valid.
- in_ready  output  1  stage can accept a word this cycle.
- sum  input  N  adder sum.
- carry_out  input  1  adder carry out of bit N-1.
- a_msb  input  1  bit N-1 of operand A.
- b_msb  input  1  bit N-1 of operand B, pre-inversion (as presented by the user, not after the subtract mux).
- alu_control  input  2  operation code: 00 ADD, 01 SUB, 10 AND, 11 OR.
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the output word.
- result  output  N  registered result.
- flag_z  output  1  result == 0.
- flag_n  output  1  result[N-1].
- flag_c  output  1  carry flag.
- flag_v  output  1  signed overflow flag.
- sticky_v  output  1  sticky overflow.
- clear_sticky  input  1  clears sticky_v.
- result_count  output  CNT_W  number of words accepted since reset.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-high and has priority over every other input.
  - During a reset cycle, in_valid, out_ready and clear_sticky are ignored.
- Reset values:
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - result = 0, all flags = 0, sticky_v = 0, result_count = 0.
  - Skid contents discarded.
- Transfers:
  - Accept: in_valid && in_ready.
  - Emit: out_valid && out_ready.
  - in_valid must not depend on in_ready; out_ready may toggle freely.
- Flag computation (at accept time, stored with the word):
  - Z = (sum == 0); N = sum[N-1].
  - ADD: C = carry_out; V = (a_msb == b_msb) && (sum[N-1] != a_msb).
  - SUB: C = carry_out (1 means no borrow); V = (a_msb != b_msb) && (sum[N-1] != a_msb).
  - AND/OR: C = 0, V = 0.
- State machine (registered; in_ready = (state != FULL), out_valid = (state != EMPTY)):
  - EMPTY: accept -> HOLD, main register loaded.
  - HOLD, accept and emit: stay HOLD; main reloaded with the new word.
  - HOLD, accept without emit: -> FULL; new word goes to the skid register and main is unchanged.
  - HOLD, emit without accept: -> EMPTY.
  - HOLD, neither: hold.
  - FULL: no accept possible. Emit -> HOLD, main <= skid. No emit -> hold.
- Timing and ordering:
  - Latency is 1 cycle: a word accepted on edge k drives out_valid/result after edge k.
  - Throughput is 1 word/cycle while out_ready stays high.
  - Words are emitted strictly in acceptance order; none dropped or duplicated.
  - result and flags stay stable while out_valid = 1 and out_ready = 0.
- sticky_v:
  - Set on accepting a word with V = 1.
  - Cleared by clear_sticky.
  - If set and clear occur in the same cycle, set wins.
- result_count:
  - Increments on every accept.
  - Wraps from 2^CNT_W - 1 to 0 with no flag.
- Reset mid-operation (HOLD or FULL): next cycle is EMPTY with all outputs at reset values; buffered words are lost.

Test Plan (N = 4):
- ADD 0111 + 0001: sum = 1000, carry_out = 0, a_msb = 0, b_msb = 0 -> result 1000, Z = 0, N = 1, C = 0, V = 1, sticky_v = 1, one cycle after accept.
- SUB 0101 - 0101: sum = 0000, carry_out = 1, a_msb = 0, b_msb = 0 -> Z = 1, N = 0, C = 1, V = 0.
- Backpressure:
  - Stimulus: out_ready = 0, in_valid held high with words W1, W2, W3.
  - W1 and W2 are accepted; in_ready = 0 after W2; W3 is held by upstream.
  - Raise out_ready -> emitted in order W1, W2, W3; result_count = 3.
- Streaming: 8 consecutive words with out_ready = 1 -> one accept and one emit per cycle, in_ready never drops, outputs match inputs delayed by 1 cycle.
- Sticky:
  - AND op with sum = 0000 -> C = V = 0.
  - Then an overflowing ADD in the same cycle as clear_sticky = 1 -> sticky_v stays 1.
  - clear_sticky alone -> sticky_v = 0.
- Reset in FULL: assert rst for 1 cycle -> next cycle out_valid = 0, in_ready = 1, result_count = 0, sticky_v = 0; a subsequent word is emitted correctly.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: derives Z/N/C/V at accept time and hands
// result+flags downstream through a 2-entry skid buffer (registered in_ready).
module alu_result_stage #(
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     sum,
    input  logic             carry_out,
    input  logic             a_msb,
    input  logic             b_msb,
    input  logic [1:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             sticky_v,
    input  logic             clear_sticky,
    output logic [CNT_W-1:0] result_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD  = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [N-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } word_t;

    state_t state, state_nx;
    word_t  main_q, skid_q, word_in;
    logic   accept, emit;
    logic   load_main, load_skid, pop_skid;

    assign in_ready  = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    // b_msb is the user operand bit, so the SUB overflow test uses a != b
    always_comb begin
        word_in     = '0;
        word_in.res = sum;
        word_in.z   = (sum == '0);
        word_in.n   = sum[N-1];
        case (alu_control)
            2'b00: begin
                word_in.c = carry_out;
                word_in.v = (a_msb == b_msb) && (sum[N-1] != a_msb);
            end
            2'b01: begin
                word_in.c = carry_out;
                word_in.v = (a_msb != b_msb) && (sum[N-1] != a_msb);
            end
            default: begin
                word_in.c = 1'b0;
                word_in.v = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_nx  = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx  = HOLD;
                    load_main = 1'b1;
                end
            end
            HOLD: begin
                if (accept && emit) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_nx  = FULL;
                    load_skid = 1'b1;
                end else if (emit) begin
                    state_nx = EMPTY;
                end
            end
            FULL: begin
                if (emit) begin
                    state_nx = HOLD;
                    pop_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            main_q       <= '0;
            skid_q       <= '0;
            sticky_v     <= 1'b0;
            result_count <= '0;
        end else begin
            state <= state_nx;
            if (load_main) begin
                main_q <= word_in;
            end else if (pop_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= word_in;
            end
            // a new overflow beats a simultaneous clear
            if (accept && word_in.v) begin
                sticky_v <= 1'b1;
            end else if (clear_sticky) begin
                sticky_v <= 1'b0;
            end
            if (accept) begin
                result_count <= result_count + CNT_W'(1);
            end
        end
    end

    assign result = main_q.res;
    assign flag_z = main_q.z;
    assign flag_n = main_q.n;
    assign flag_c = main_q.c;
    assign flag_v = main_q.v;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized + directed bench for alu_result_stage against a queue model
// that recomputes flags from the raw operands with integer arithmetic.
module tb_alu_result_stage;

    localparam int N     = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     sum;
    logic             carry_out;
    logic             a_msb;
    logic             b_msb;
    logic [1:0]       alu_control;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     result;
    logic             flag_z, flag_n, flag_c, flag_v;
    logic             sticky_v;
    logic             clear_sticky;
    logic [CNT_W-1:0] result_count;

    alu_result_stage #(.N(N), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .carry_out(carry_out),
        .a_msb(a_msb), .b_msb(b_msb),
        .alu_control(alu_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
        .sticky_v(sticky_v), .clear_sticky(clear_sticky),
        .result_count(result_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic       z, n, c, v;
    } exp_t;

    exp_t       q[$];
    exp_t       cur;
    int         m_cnt;
    bit         m_sticky;
    bit         main_zero;
    int         n_chk;
    int         n_fail;
    bit         last_acc;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want,
                     $time);
        end
    endtask

    // Build adder-side inputs and the expected word from plain arithmetic.
    task automatic drive(input bit v, input int op, input int a, input int b);
        int sa, sb, full, sres;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        case (op)
            0: begin full = a + b; sres = sa + sb; end
            1: begin full = a + (15 - b) + 1; sres = sa - sb; end
            2: begin full = (a & b) | (int'($urandom_range(0, 1)) << 4); sres = 0; end
            default: begin full = (a | b) | (int'($urandom_range(0, 1)) << 4); sres = 0; end
        endcase
        in_valid    = v;
        alu_control = 2'(op);
        sum         = 4'(full);
        carry_out   = full[4];
        a_msb       = (a >= 8);
        b_msb       = (b >= 8);
        cur.r = 4'(full);
        cur.z = (full % 16 == 0);
        cur.n = ((full % 16) >= 8);
        cur.c = (op < 2) ? full[4] : 1'b0;
        cur.v = (op < 2) ? (sres > 7 || sres < -8) : 1'b0;
    endtask

    task automatic check_outs();
        chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("count", 32'(result_count), 32'(m_cnt % (1 << CNT_W)));
        chk("sticky", 32'(sticky_v), 32'(m_sticky));
        if (q.size() > 0) begin
            chk("result", 32'(result), 32'(q[0].r));
            chk("flags", {28'd0, flag_z, flag_n, flag_c, flag_v},
                {28'd0, q[0].z, q[0].n, q[0].c, q[0].v});
        end else if (main_zero) begin
            chk("rst_result", {27'd0, result, flag_z, flag_n, flag_c, flag_v}, 32'd0);
        end
    endtask

    task automatic tick();
        bit acc, em;
        acc = !rst && in_valid && (q.size() < 2);
        em  = !rst && out_ready && (q.size() > 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt     = 0;
            m_sticky  = 0;
            main_zero = 1;
        end else begin
            if (em) void'(q.pop_front());
            if (acc) begin
                q.push_back(cur);
                m_cnt++;
                main_zero = 0;
            end
            if (acc && cur.v) m_sticky = 1;
            else if (clear_sticky) m_sticky = 0;
        end
        last_acc = acc;
        @(negedge clk);
        check_outs();
    endtask

    // Present a word and hold it until the stage takes it (bounded).
    task automatic send(input int op, input int a, input int b);
        drive(1, op, a, b);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (last_acc) break;
            if (i == 19) chk("send_timeout", 32'd1, 32'd0);
        end
        in_valid = 0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; m_cnt = 0; m_sticky = 0; main_zero = 1;
        rst = 1; out_ready = 0; clear_sticky = 0;
        drive(1, 0, 7, 1);
        tick();
        tick();
        rst = 0;
        in_valid = 0;
        tick();

        // ADD overflow then SUB to zero
        out_ready = 1;
        send(0, 7, 1);
        chk("add_res", 32'(result), 32'h8);
        chk("add_v", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'b0101);
        chk("add_sticky", 32'(sticky_v), 32'd1);
        send(1, 5, 5);
        chk("sub_flags", {27'd0, result, flag_z, flag_n, flag_c, flag_v},
            {27'd0, 4'd0, 4'b1010});
        tick();

        // Backpressure with three words
        rst = 1; tick(); rst = 0;
        out_ready = 0;
        send(0, 1, 2);
        send(0, 3, 4);
        chk("bp_full", 32'(in_ready), 32'd0);
        drive(1, 0, 5, 6);
        tick(); tick();
        out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (last_acc) in_valid = 0;
        end
        chk("bp_count", 32'(result_count), 32'd3);

        // Streaming at full rate
        for (int i = 0; i < 8; i++) begin
            drive(1, $urandom_range(0, 3), $urandom_range(0, 15),
                  $urandom_range(0, 15));
            tick();
            chk("stream_rdy", 32'(in_ready), 32'd1);
        end
        in_valid = 0;
        tick();

        // Sticky: set-wins-over-clear, then clear alone
        send(2, 4'b1010, 4'b0101);
        chk("and_cv", {30'd0, flag_c, flag_v}, 32'd0);
        clear_sticky = 1;
        send(0, 7, 1);
        chk("sticky_setwin", 32'(sticky_v), 32'd1);
        tick();
        clear_sticky = 0;
        chk("sticky_clr", 32'(sticky_v), 32'd0);

        // Reset while FULL, then one more word
        out_ready = 0;
        send(0, 7, 7);
        send(1, 8, 1);
        rst = 1; tick(); rst = 0;
        chk("rstfull_valid", 32'(out_valid), 32'd0);
        out_ready = 1;
        send(1, 2, 9);
        tick();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                  $urandom_range(0, 15), $urandom_range(0, 15));
            out_ready    = ($urandom_range(0, 2) != 0);
            clear_sticky = ($urandom_range(0, 9) == 0);
            rst          = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
